// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data access) arbiter onto one shared memory port.
// Round-robin on contention, single outstanding command, wait-cycle timeout with error pulse.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic          err,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t        state_q, state_d;
  grant_t        last_q, last_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          m_req_q, m_req_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          i_eff, d_eff, pick_d;

  // A requester acked this cycle is masked so a held request is not re-granted immediately.
  assign i_eff  = i_req & ~i_ack_q;
  assign d_eff  = d_req & ~d_ack_q;
  assign pick_d = d_eff & (~i_eff | (last_q == GRANT_I));

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_eff || d_eff) begin
          m_req_d   = 1'b1;
          m_addr_d  = pick_d ? d_addr : i_addr;
          m_we_d    = pick_d & d_we;
          m_wdata_d = d_wdata;
          last_d    = pick_d ? GRANT_D : GRANT_I;
          cnt_d     = '0;
          state_d   = pick_d ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_ready) begin
          m_req_d = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
          if (state_q == BUSY_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = m_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!m_we_q) d_rdata_d = m_rdata;
          end
        end else if (cnt_q + 8'd1 == TO_LIM) begin
          // Abort on the TIMEOUT-th unanswered cycle: m_req stays high exactly TIMEOUT cycles.
          m_req_d = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
          if (state_q == BUSY_I) i_ack_d = 1'b1;
          else                   d_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_q    <= GRANT_I;
      cnt_q     <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign err     = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random transactions
// checked against a transaction-level model of grant order, latency and timeout.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we, m_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, m_rdata;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic          i_ack, d_ack, m_req, m_we, err, busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: last served requester (1 = D), held read data, ack seen in current cycle.
  bit            mdl_last;
  logic [DW-1:0] mdl_ird, mdl_drd;
  bit            mdl_ack_i, mdl_ack_d;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("ack_exclusive", {31'b0, i_ack & d_ack}, 32'd0);
  endtask

  task automatic mdl_reset();
    mdl_last  = 1'b0;
    mdl_ird   = '0;
    mdl_drd   = '0;
    mdl_ack_i = 1'b0;
    mdl_ack_d = 1'b0;
  endtask

  // One arbitration attempt starting from IDLE. lat = unanswered cycles before m_ready.
  task automatic xact(input logic ir, input logic dr, input logic dwe,
                      input logic [31:0] ia, input logic [31:0] da,
                      input logic [31:0] dwd, input logic [31:0] rd,
                      input int lat, input bit drop);
    bit ei, ed, g, ready_now;
    logic [31:0] e_addr;
    logic        e_we;
    i_req = ir; d_req = dr; d_we = dwe;
    i_addr = ia; d_addr = da; d_wdata = dwd;
    m_ready = 1'($urandom % 2);   // must be ignored while idle
    m_rdata = $urandom;
    ei = ir && !mdl_ack_i;
    ed = dr && !mdl_ack_d;
    if (!ei && !ed) begin
      step();
      chk("nogrant_mreq", {31'b0, m_req}, 32'd0);
      chk("nogrant_busy", {31'b0, busy}, 32'd0);
      chk("nogrant_iack", {31'b0, i_ack}, 32'd0);
      chk("nogrant_dack", {31'b0, d_ack}, 32'd0);
      mdl_ack_i = 1'b0;
      mdl_ack_d = 1'b0;
      return;
    end
    g        = (ei && ed) ? !mdl_last : ed;
    mdl_last = g;
    e_addr   = g ? da : ia;
    e_we     = g ? dwe : 1'b0;
    step();
    chk("grant_mreq", {31'b0, m_req}, 32'd1);
    chk("grant_busy", {31'b0, busy}, 32'd1);
    chk("grant_maddr", m_addr, e_addr);
    chk("grant_mwe", {31'b0, m_we}, {31'b0, e_we});
    if (g) chk("grant_mwdata", m_wdata, dwd);
    chk("grant_acks", {30'b0, i_ack, d_ack}, 32'd0);
    if (drop) begin
      i_req = 1'b0;
      d_req = 1'b0;
    end
    for (int j = 1; j <= TO; j++) begin
      ready_now = (j == lat + 1);
      m_ready = ready_now;
      m_rdata = rd;
      i_addr  = $urandom;
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_we    = 1'($urandom % 2);
      step();
      if (ready_now || j == TO) break;
      chk("wait_mreq", {31'b0, m_req}, 32'd1);
      chk("wait_busy", {31'b0, busy}, 32'd1);
      chk("wait_maddr", m_addr, e_addr);
      chk("wait_mwe", {31'b0, m_we}, {31'b0, e_we});
      if (g) chk("wait_mwdata", m_wdata, dwd);
      chk("wait_acks", {29'b0, i_ack, d_ack, err}, 32'd0);
    end
    if (ready_now && !e_we) begin
      if (g) mdl_drd = rd;
      else   mdl_ird = rd;
    end
    chk("done_iack", {31'b0, i_ack}, {31'b0, !g});
    chk("done_dack", {31'b0, d_ack}, {31'b0, g});
    chk("done_err", {31'b0, err}, {31'b0, !ready_now});
    chk("done_mreq", {31'b0, m_req}, 32'd0);
    chk("done_busy", {31'b0, busy}, 32'd0);
    chk("done_irdata", i_rdata, mdl_ird);
    chk("done_drdata", d_rdata, mdl_drd);
    mdl_ack_i = !g;
    mdl_ack_d = g;
    m_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; m_ready = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
    mdl_reset();
    step();
    step();
    chk("rst_mreq", {31'b0, m_req}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_flags", {28'b0, i_ack, d_ack, err, m_we}, 32'd0);
    chk("rst_maddr", m_addr, 32'd0);
    chk("rst_mwdata", m_wdata, 32'd0);
    chk("rst_irdata", i_rdata, 32'd0);
    chk("rst_drdata", d_rdata, 32'd0);
    reset = 1'b1;

    // Contention from reset: D, then I, then D again.
    xact(1, 1, 0, 32'h10, 32'h20, 32'h0, 32'h1111, 0, 0);
    xact(1, 1, 0, 32'h10, 32'h20, 32'h0, 32'h2222, 0, 0);
    xact(1, 1, 0, 32'h10, 32'h20, 32'h0, 32'h3333, 1, 0);
    xact(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
    // Single fetch.
    xact(1, 0, 0, 32'h40, 32'h0, 32'h0, 32'h00500093, 0, 0);
    // Data write leaves d_rdata unchanged.
    xact(0, 1, 1, 32'h0, 32'h100, 32'hCAFEF00D, 32'hDEADBEEF, 3, 0);
    // Timeout abort.
    xact(0, 1, 0, 32'h0, 32'h200, 32'h0, 32'h5555, 100, 0);
    // Held fetch request: ack, masked idle cycle, ack.
    xact(1, 0, 0, 32'h80, 32'h0, 32'h0, 32'hA1, 0, 0);
    xact(1, 0, 0, 32'h80, 32'h0, 32'h0, 32'hA2, 0, 0);
    xact(1, 0, 0, 32'h84, 32'h0, 32'h0, 32'hA3, 0, 0);
    // Request dropped before ack still completes.
    xact(0, 1, 0, 32'h0, 32'h300, 32'h0, 32'hB0B0, 2, 1);

    // Reset in the middle of a fetch wait.
    i_req = 1; d_req = 0; m_ready = 0; i_addr = 32'h400;
    step();
    chk("rstmid_grant", {31'b0, m_req}, 32'd1);
    i_req = 0;
    step(); step(); step();
    reset = 1'b0;
    step();
    chk("rstmid_mreq", {31'b0, m_req}, 32'd0);
    chk("rstmid_busy", {31'b0, busy}, 32'd0);
    chk("rstmid_ack", {29'b0, i_ack, d_ack, err}, 32'd0);
    reset = 1'b1;
    m_ready = 1; m_rdata = 32'h77;
    step();
    chk("rstmid_ignored", {28'b0, i_ack, d_ack, err, m_req}, 32'd0);
    chk("rstmid_irdata", i_rdata, 32'd0);
    m_ready = 0;
    mdl_reset();

    // Random transactions.
    for (int n = 0; n < 300; n++) begin
      xact(1'($urandom % 4 != 0), 1'($urandom % 2), 1'($urandom % 2),
           $urandom, $urandom, $urandom, $urandom,
           int'($urandom_range(0, 18)), 1'($urandom % 4 == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, 32, address width.
REQ-002 Parameter: DW, 32, data width.
REQ-003 Parameter: TIMEOUT, 15, maximum wait cycles for m_ready before abort (1..255).
REQ-004 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-low reset.
REQ-006 Port: i_req  in  1  instruction-fetch request (read only).
REQ-007 Port: i_addr  in  AW  fetch address.
REQ-008 Port: i_rdata  out  DW  fetch read data, valid when i_ack=1.
REQ-009 Port: i_ack  out  1  one-cycle fetch completion pulse.
REQ-010 Port: d_req  in  1  data-access request.
REQ-011 Port: d_we  in  1  data write enable (1=write, 0=read).
REQ-012 Port: d_addr  in  AW  data address.
REQ-013 Port: d_wdata  in  DW  data write value.
REQ-014 Port: d_rdata  out  DW  data read value, valid when d_ack=1.
REQ-015 Port: d_ack  out  1  one-cycle data completion pulse.
REQ-016 Port: m_req  out  1  shared memory request, held until m_ready or abort.
REQ-017 Port: m_we, m_addr, m_wdata  out  1/AW/DW  latched command to memory.
REQ-018 Port: m_rdata  in  DW  memory read data, valid with m_ready.
REQ-019 Port: m_ready  in  1  memory completion strobe.
REQ-020 Port: err  out  1  one-cycle pulse, coincident with ack, on timeout abort.
REQ-021 Port: busy  out  1  high whenever state is not IDLE.

Function
REQ-022 FSM states SHALL be IDLE, BUSY_I, BUSY_D; all outputs registered.
REQ-023 In IDLE, effective request x_eff = x_req AND NOT x_ack (masks the requester acked in the current cycle).
REQ-024 IDLE, single x_eff: grant x; both: grant the requester not served last (last_grant register, reset value I, so D wins the first contention).
REQ-025 On grant edge: latch address, wdata, we (we forced 0 for I) into m_* registers, set m_req=1, update last_grant, enter BUSY_x.
REQ-026 BUSY_x, m_ready=1: m_req->0, x_ack=1 for one cycle, x_rdata<=m_rdata (reads only; writes leave d_rdata unchanged), wait counter cleared, return to IDLE.
REQ-027 Minimum latency: req sampled at edge k, m_req high after k, m_ready high before edge k+1 -> ack high in cycle after edge k+1 (2 cycles req-to-ack).
REQ-028 One IDLE cycle SHALL separate consecutive grants; no back-to-back m_req without a low cycle.
REQ-029 Wait counter (8-bit) increments each BUSY cycle with m_ready=0; on reaching TIMEOUT: m_req->0, x_ack=1 and err=1 for one cycle, x_rdata unchanged, return to IDLE.
REQ-030 m_ready and m_rdata SHALL be ignored in IDLE.
REQ-031 Requester deasserting req before ack SHALL NOT abort the transaction; ack is still issued.
REQ-032 m_* command registers SHALL hold stable for the whole BUSY period, independent of requester inputs.
REQ-033 i_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-034 reset=0 at an edge: state IDLE, m_req/m_we/i_ack/d_ack/err/busy=0, m_addr/m_wdata/i_rdata/d_rdata=0, counter=0, last_grant=I.
REQ-035 Reset mid-transaction SHALL abandon it: no ack, no err; m_req low from the next cycle.

Verification
REQ-036 Single fetch: i_req, i_addr=0x40, m_ready 1 cycle after m_req with m_rdata=0x00500093 -> i_ack 1 cycle, i_rdata=0x00500093, err=0.
REQ-037 Contention: i_req and d_req both high from reset -> D granted first, then I after one IDLE cycle; next contention grants D again only after I served.
REQ-038 Data write: d_we=1, d_addr=0x100, d_wdata=0xCAFEF00D -> m_we=1, m_addr=0x100, m_wdata=0xCAFEF00D held until m_ready; d_ack pulse; d_rdata unchanged.
REQ-039 Timeout: TIMEOUT=15, m_ready held 0 -> m_req high exactly 15 cycles, then d_ack=1 and err=1 same cycle, busy=0 next cycle.
REQ-040 Reset mid-BUSY_I (m_req=1, cycle 3 of wait) -> next cycle m_req=0, busy=0, i_ack=0; later m_ready pulse ignored.
REQ-041 Held request: i_req held high continuously, m_ready immediate -> one ack per transaction, separated by one IDLE cycle, no duplicate grant in the ack cycle.
